// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: word width, default timeout
// and the access state encoding.
package mem_access_unit_pkg;

  localparam int MAU_WORD_SIZE   = 16;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_wait_counter.sv
// Wait-cycle counter for one memory access. It flags expiry on the cycle where
// the count would reach TIMEOUT without a handshake.
module mem_wait_counter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multi-cycle CPU: runs the request/ready handshake,
// owns IR and MDR, and stalls the control unit while an access is in flight.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WORD_SIZE = MAU_WORD_SIZE,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic [WORD_SIZE-1:0] write_data,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic                 IorD,
  input  logic                 IRWrite,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] mdr,
  output logic                 mem_busy,
  output logic                 mem_done,
  output logic                 access_error,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_read_req,
  output logic                 mem_write_req,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  input  logic                 mem_ack
);

  mau_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] inst_q, inst_d;
  logic [WORD_SIZE-1:0] mdr_q, mdr_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 ir_sel_q, ir_sel_d;
  logic                 err_q, err_d;
  logic                 cnt_clear, cnt_en, cnt_expired;

  mem_wait_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_counter (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_en),
    .expired_o (cnt_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    mdr_d         = mdr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    ir_sel_d      = ir_sel_q;
    err_d         = err_q;
    mem_busy      = 1'b0;
    mem_done      = 1'b0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (MemRead && MemWrite) begin
          err_d = 1'b1;
        end else if (MemRead || MemWrite) begin
          mem_busy  = 1'b1;
          cnt_clear = 1'b1;
          addr_d    = IorD ? alu_out : pc;
          ir_sel_d  = IRWrite;
          if (MemWrite) wdata_d = write_data;
          state_d = MemRead ? ST_RD_WAIT : ST_WR_WAIT;
        end
      end

      ST_RD_WAIT: begin
        mem_busy     = 1'b1;
        mem_read_req = 1'b1;
        if (mem_ready) begin
          mdr_d = mem_rdata;
          if (ir_sel_q) inst_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_WR_WAIT: begin
        mem_busy      = 1'b1;
        mem_write_req = 1'b1;
        if (mem_ack) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        mem_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      inst_q   <= '0;
      mdr_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ir_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      mdr_q    <= mdr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ir_sel_q <= ir_sel_d;
      err_q    <= err_d;
    end
  end

  assign inst         = inst_q;
  assign mdr          = mdr_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign access_error = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a transaction-level
// model: a memory array, expected IR/MDR contents and handshake cycle counts.
module tb_mem_access_unit;

  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pc, alu_out, write_data;
  logic         MemRead, MemWrite, IorD, IRWrite;
  logic [W-1:0] inst, mdr, mem_addr, mem_wdata;
  logic         mem_busy, mem_done, access_error;
  logic         mem_read_req, mem_write_req;
  logic [W-1:0] mem_rdata;
  logic         mem_ready, mem_ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] mem_model [logic [W-1:0]];
  logic [W-1:0] exp_inst = '0;
  logic [W-1:0] exp_mdr  = '0;
  logic         exp_err  = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .WORD_SIZE (W),
    .TIMEOUT   (TO),
    .CNT_W     (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .alu_out       (alu_out),
    .write_data    (write_data),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .IorD          (IorD),
    .IRWrite       (IRWrite),
    .inst          (inst),
    .mdr           (mdr),
    .mem_busy      (mem_busy),
    .mem_done      (mem_done),
    .access_error  (access_error),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .mem_ack       (mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_inst"}, inst, exp_inst);
    check({tag, "_mdr"}, mdr, exp_mdr);
    check({tag, "_err"}, access_error, exp_err);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0; mem_ack = 1'b0;
    exp_inst = '0; exp_mdr = '0; exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete access; lat = wait cycle on which memory answers, 0 = never.
  task automatic access(input bit is_rd, input bit iord, input bit irw,
                        input logic [W-1:0] pc_v, input logic [W-1:0] alu_v,
                        input logic [W-1:0] wd_v, input int lat);
    logic [W-1:0] addr, rdata;
    int  busy_n, n, exp_waits;
    bit  done, timed_out;
    addr  = iord ? alu_v : pc_v;
    rdata = W'($urandom);
    if (is_rd) begin
      if (!mem_model.exists(addr)) mem_model[addr] = W'($urandom);
      rdata = mem_model[addr];
    end
    timed_out = (lat == 0) || (lat > TO);
    exp_waits = timed_out ? TO : lat;

    @(negedge clk);
    MemRead = is_rd; MemWrite = !is_rd; IorD = iord; IRWrite = irw;
    pc = pc_v; alu_out = alu_v; write_data = wd_v;
    #1;
    check("idle_busy", mem_busy, 1);
    check("idle_no_req", {mem_read_req, mem_write_req}, 0);
    busy_n = 1; n = 0; done = 0;

    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    pc = W'($urandom); alu_out = W'($urandom); write_data = W'($urandom);
    IorD = 1'($urandom); IRWrite = 1'($urandom);
    while (!done && n < TO + 4) begin
      #1;
      if (mem_done) begin
        done = 1;
      end else begin
        n++;
        busy_n += int'(mem_busy);
        check("wait_req", {mem_read_req, mem_write_req}, is_rd ? 2'b10 : 2'b01);
        check("wait_addr", mem_addr, addr);
        if (!is_rd) check("wait_wdata", mem_wdata, wd_v);
        if (n == lat) begin
          if (is_rd) begin
            mem_ready = 1'b1; mem_rdata = rdata;
          end else begin
            mem_ack = 1'b1;
          end
        end
        @(negedge clk);
        mem_ready = 1'b0; mem_ack = 1'b0; mem_rdata = W'($urandom);
      end
    end

    if (!timed_out && is_rd) begin
      exp_mdr = rdata;
      if (irw) exp_inst = rdata;
    end
    if (!timed_out && !is_rd) mem_model[addr] = wd_v;
    if (timed_out) exp_err = 1'b1;

    check("done_seen", done, 1);
    check("wait_cycles", n, exp_waits);
    check("busy_cycles", busy_n, exp_waits + 1);
    check("done_busy", mem_busy, 0);
    check("done_no_req", {mem_read_req, mem_write_req}, 0);
    check_regs("done");

    // Handshake strobes outside a wait state must be ignored.
    mem_ready = 1'b1; mem_ack = 1'b1; mem_rdata = ~rdata;
    @(negedge clk);
    mem_ready = 1'b0; mem_ack = 1'b0;
    #1;
    check("done_pulse_width", mem_done, 0);
    check("idle_after_busy", mem_busy, 0);
    check("idle_after_no_req", {mem_read_req, mem_write_req}, 0);
    check_regs("idle_after");
  endtask

  initial begin
    reset = 1'b1;
    pc = '0; alu_out = '0; write_data = '0;
    MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_inst", inst, 0);
    check("rst_mdr", mdr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_reqs", {mem_read_req, mem_write_req}, 0);
    check("rst_busy_done_err", {mem_busy, mem_done, access_error}, 0);
    reset = 1'b0;

    // Instruction fetch, data load (minimum latency), store.
    mem_model[16'h0010] = 16'h6A05;
    access(1, 0, 1, 16'h0010, 16'h0000, 16'h0000, 3);
    check("fetch_inst", inst, 16'h6A05);
    mem_model[16'h0042] = 16'hBEEF;
    access(1, 1, 0, 16'h0000, 16'h0042, 16'h0000, 1);
    check("load_mdr", mdr, 16'hBEEF);
    check("load_inst_kept", inst, 16'h6A05);
    access(0, 1, 0, 16'h0000, 16'h0080, 16'h1234, 2);

    // Ready arriving on the very last allowed wait cycle is still accepted.
    access(1, 1, 1, 16'h0000, 16'h0080, 16'h0000, TO);
    check("late_ready_inst", inst, 16'h1234);

    for (int i = 0; i < 24; i++) begin
      access(1'($urandom), 1'($urandom), 1'($urandom),
             W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
             W'($urandom), $urandom_range(1, TO));
    end

    // Read timeout; the error flag must stay set while idle.
    access(1, 0, 1, 16'h0033, 16'h0000, 16'h0000, 0);
    repeat (2) @(negedge clk);
    #1;
    check("err_sticky", access_error, 1);

    apply_reset();
    access(0, 1, 0, 16'h0000, 16'h0007, 16'hCAFE, 0);

    // Both read and write requested at once.
    apply_reset();
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b1; IorD = 1'b0; pc = 16'h0055;
    #1;
    check("illegal_busy", mem_busy, 0);
    check("illegal_no_req", {mem_read_req, mem_write_req}, 0);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    check("illegal_err", access_error, 1);
    check("illegal_still_no_req", {mem_read_req, mem_write_req, mem_done}, 0);
    check("illegal_addr_kept", mem_addr, 0);

    // Reset in the middle of a read, then a normal fetch.
    apply_reset();
    access(1, 0, 1, 16'h0003, 16'h0000, 16'h0000, 1);
    @(negedge clk);
    MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 16'h0021;
    @(negedge clk);
    MemRead = 1'b0;
    #1;
    check("mid_rd_req", mem_read_req, 1);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    #1;
    reset = 1'b1;
    exp_inst = '0; exp_mdr = '0; exp_err = 1'b0;
    #1;
    check("mid_rst_reqs", {mem_read_req, mem_write_req}, 0);
    check("mid_rst_busy", mem_busy, 0);
    check("mid_rst_addr", mem_addr, 0);
    check_regs("mid_rst");
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    mem_model[16'h0021] = 16'h4321;
    access(1, 0, 1, 16'h0021, 16'h0000, 16'h0000, 2);
    check("post_rst_fetch", inst, 16'h4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
